// File: rtl/trail_writer_mp.sv
// trail_writer_mp: multi-player trail writer.
// On each in-play frame tick it samples every player's cell and direction,
// queues one job per moving player and fills that cell into the frame
// buffer through a ready/valid write port, lowest player index first.
// Optional macro TRAIL_COLLIDE_EN adds a read-before-write collision check.
module trail_writer_mp #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         COORD_W     = 8,
  parameter int         ADDR_W      = 20,
  parameter int         DATA_W      = 16,
  parameter int         CELL_WORDS  = 4,
  parameter int         ROW_STRIDE  = 1280,
  parameter int         X_OFF       = 20,
  parameter int         Y_OFF       = 20,
  parameter logic [2:0] PLAY_STATE  = 3'b010
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_clk,
  input  logic [2:0]                     Game_State,
  input  logic [NUM_PLAYERS*COORD_W-1:0] pos_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0] pos_y,
  input  logic [NUM_PLAYERS*2-1:0]       dir,
  output logic                           fb_we,
  input  logic                           fb_ready,
  output logic [ADDR_W-1:0]              fb_addr,
  output logic [DATA_W-1:0]              fb_wdata,
  output logic                           fb_re,
  input  logic [DATA_W-1:0]              fb_rdata,
  output logic                           busy,
  output logic [NUM_PLAYERS-1:0]         overrun,
  output logic [NUM_PLAYERS-1:0]         collision
);

  localparam int PID_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int W_W   = $clog2(CELL_WORDS + 1);

  typedef enum logic [2:0] {IDLE, SELECT, CHECK, WAIT_RD, WRITE, NEXT} state_t;

  state_t                 state_q, state_d;
  logic                   fclk_q, fclk_dly_q;
  logic                   tick, play;
  logic                   primed_q, primed_d;
  logic [NUM_PLAYERS-1:0] pending_q, pending_d, pending_set, clr_mask;
  logic [NUM_PLAYERS-1:0] overrun_q, overrun_d;
  logic [COORD_W-1:0]     old_x_q [NUM_PLAYERS];
  logic [COORD_W-1:0]     old_x_d [NUM_PLAYERS];
  logic [COORD_W-1:0]     old_y_q [NUM_PLAYERS];
  logic [COORD_W-1:0]     old_y_d [NUM_PLAYERS];
  logic [1:0]             old_dir_q [NUM_PLAYERS];
  logic [1:0]             old_dir_d [NUM_PLAYERS];
  logic [COORD_W-1:0]     job_x_q [NUM_PLAYERS];
  logic [COORD_W-1:0]     job_x_d [NUM_PLAYERS];
  logic [COORD_W-1:0]     job_y_q [NUM_PLAYERS];
  logic [COORD_W-1:0]     job_y_d [NUM_PLAYERS];
  logic [1:0]             job_t_q [NUM_PLAYERS];
  logic [1:0]             job_t_d [NUM_PLAYERS];
  logic [PID_W-1:0]       cur_pid_q, cur_pid_d, pick, active_pid;
  logic                   active_vld;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [DATA_W-1:0]      word_q, word_d;
  logic [W_W-1:0]         w_q, w_d;
`ifdef TRAIL_COLLIDE_EN
  logic [NUM_PLAYERS-1:0] collision_q, collision_d;
`endif

  function automatic logic [ADDR_W-1:0] cell_base(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    logic [ADDR_W-1:0] ax, ay;
    ax = ADDR_W'(x) + ADDR_W'(X_OFF);
    ay = ADDR_W'(y) + ADDR_W'(Y_OFF);
    return ay * ADDR_W'(ROW_STRIDE) + ax * ADDR_W'(CELL_WORDS);
  endfunction

  function automatic logic [DATA_W-1:0] make_word(input logic [PID_W-1:0] pid,
                                                  input logic [1:0] t);
    logic [DATA_W-1:0] w;
    w = '0;
    w[PID_W+1:0] = {pid, t};
    return w;
  endfunction

  assign play = (Game_State == PLAY_STATE);
  assign tick = fclk_q & ~fclk_dly_q;
  assign busy = (state_q != IDLE);
  assign overrun = overrun_q;

  // Frame tick edge detect; reset preloads both flops so no false edge follows reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fclk_q     <= frame_clk;
      fclk_dly_q <= frame_clk;
    end else begin
      fclk_q     <= frame_clk;
      fclk_dly_q <= fclk_q;
    end
  end

  // Fixed-priority pick of the lowest-index pending player
  always_comb begin
    pick = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--)
      if (pending_q[p]) pick = PID_W'(p);
  end

  // The player being serviced keeps its job registers frozen until NEXT
  always_comb begin
    active_vld = (state_q == SELECT) || (state_q == CHECK) ||
                 (state_q == WAIT_RD) || (state_q == WRITE);
    active_pid = (state_q == SELECT) ? pick : cur_pid_q;
  end

  // Per-tick move classification, job latching and overrun detection
  always_comb begin
    logic [COORD_W-1:0] px, py;
    logic [1:0]         pd;
    px          = '0;
    py          = '0;
    pd          = '0;
    primed_d    = primed_q;
    pending_set = '0;
    overrun_d   = overrun_q;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      old_x_d[p]   = old_x_q[p];
      old_y_d[p]   = old_y_q[p];
      old_dir_d[p] = old_dir_q[p];
      job_x_d[p]   = job_x_q[p];
      job_y_d[p]   = job_y_q[p];
      job_t_d[p]   = job_t_q[p];
    end
    if (tick && play) begin
      primed_d = 1'b1;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        px = pos_x[p*COORD_W +: COORD_W];
        py = pos_y[p*COORD_W +: COORD_W];
        pd = dir[p*2 +: 2];
        if (primed_q && ((px != old_x_q[p]) || (py != old_y_q[p]))) begin
          pending_set[p] = 1'b1;
          if (pending_q[p]) overrun_d[p] = 1'b1;
          if (!(active_vld && (active_pid == PID_W'(p)))) begin
            job_x_d[p] = px;
            job_y_d[p] = py;
            job_t_d[p] = (pd != old_dir_q[p]) ? 2'd3 : (pd[1] ? 2'd1 : 2'd2);
          end
        end
        old_x_d[p]   = px;
        old_y_d[p]   = py;
        old_dir_d[p] = pd;
      end
    end
    if (!play) begin
      primed_d  = 1'b0;
      overrun_d = '0;
    end
  end

  // Write FSM: next state and port outputs
  always_comb begin
    state_d   = state_q;
    cur_pid_d = cur_pid_q;
    base_d    = base_q;
    word_d    = word_q;
    w_d       = w_q;
    clr_mask  = '0;
    fb_we     = 1'b0;
    fb_addr   = '0;
    fb_wdata  = '0;
`ifdef TRAIL_COLLIDE_EN
    fb_re       = 1'b0;
    collision_d = collision_q;
`endif
    case (state_q)
      IDLE:   if (|pending_q) state_d = SELECT;
      SELECT: begin
        cur_pid_d = pick;
        base_d    = cell_base(job_x_q[pick], job_y_q[pick]);
        word_d    = make_word(pick, job_t_q[pick]);
        w_d       = '0;
`ifdef TRAIL_COLLIDE_EN
        state_d   = CHECK;
`else
        state_d   = WRITE;
`endif
      end
`ifdef TRAIL_COLLIDE_EN
      CHECK: begin
        fb_re   = 1'b1;
        fb_addr = base_q;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (fb_rdata != '0) collision_d[cur_pid_q] = 1'b1;
        state_d = WRITE;
      end
`endif
      WRITE: begin
        fb_we    = 1'b1;
        fb_addr  = base_q + ADDR_W'(w_q);
        fb_wdata = word_q;
        if (fb_ready) begin
          if (w_q == W_W'(CELL_WORDS - 1)) state_d = NEXT;
          else w_d = w_q + W_W'(1);
        end
      end
      NEXT: begin
        clr_mask[cur_pid_q] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!play) begin
      state_d  = IDLE;
      fb_we    = 1'b0;
      fb_addr  = '0;
      fb_wdata = '0;
`ifdef TRAIL_COLLIDE_EN
      fb_re       = 1'b0;
      collision_d = '0;
`endif
    end
  end

`ifdef TRAIL_COLLIDE_EN
  assign collision = collision_q;
`else
  logic rdata_unused;
  assign rdata_unused = ^fb_rdata;
  assign fb_re        = 1'b0;
  assign collision    = '0;
`endif

  // Pending bits: NEXT clears the serviced player, a same-cycle tick wins
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | pending_set;
    if (!play) pending_d = '0;
  end

  // Control state with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      primed_q  <= 1'b0;
      pending_q <= '0;
      overrun_q <= '0;
`ifdef TRAIL_COLLIDE_EN
      collision_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      primed_q  <= primed_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
`ifdef TRAIL_COLLIDE_EN
      collision_q <= collision_d;
`endif
    end
  end

  // Job and working data registers, only meaningful once qualified by control
  always_ff @(posedge Clk) begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      old_x_q[p]   <= old_x_d[p];
      old_y_q[p]   <= old_y_d[p];
      old_dir_q[p] <= old_dir_d[p];
      job_x_q[p]   <= job_x_d[p];
      job_y_q[p]   <= job_y_d[p];
      job_t_q[p]   <= job_t_d[p];
    end
    cur_pid_q <= cur_pid_d;
    base_q    <= base_d;
    word_q    <= word_d;
    w_q       <= w_d;
  end

endmodule

// File: tb/tb_trail_writer_mp.sv
// Self-checking bench for trail_writer_mp (two players, default geometry).
module tb_trail_writer_mp;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [2:0]  Game_State = 3'b010;
  logic [15:0] pos_x = '0;
  logic [15:0] pos_y = '0;
  logic [3:0]  dir = '0;
  logic        fb_we;
  logic        fb_ready = 1'b1;
  logic [19:0] fb_addr;
  logic [15:0] fb_wdata;
  logic        fb_re;
  logic [15:0] fb_rdata = '0;
  logic        busy;
  logic [1:0]  overrun;
  logic [1:0]  collision;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;
  bit   tog_en = 1'b0;

  trail_writer_mp dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir),
    .fb_we(fb_we), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_re(fb_re), .fb_rdata(fb_rdata), .busy(busy),
    .overrun(overrun), .collision(collision)
  );

  always #5 Clk = ~Clk;

  // Monitor: every accepted word must match the scoreboard head; a stalled
  // word must already show the head's address and data
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (fb_we && fb_ready) begin
        accepts++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%h", fb_addr, fb_wdata);
        end else begin
          e = sb.pop_front();
          if (fb_addr !== e.addr || fb_wdata !== e.data) begin
            errors++;
            $display("FAIL write addr=%0d data=%h expected addr=%0d data=%h",
                     fb_addr, fb_wdata, e.addr, e.data);
          end
        end
      end else if (fb_we && sb.size() != 0) begin
        checks++;
        if (fb_addr !== sb[0].addr || fb_wdata !== sb[0].data) begin
          errors++;
          $display("FAIL stall_hold addr=%0d data=%h expected addr=%0d data=%h",
                   fb_addr, fb_wdata, sb[0].addr, sb[0].data);
        end
      end
    end
  end

  // fb_ready toggler for the back-pressure test
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (tog_en) fb_ready = ~fb_ready;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_p(input int p, input logic [7:0] x, input logic [7:0] y,
                       input logic [1:0] d);
    pos_x[p*8 +: 8] = x;
    pos_y[p*8 +: 8] = y;
    dir[p*2 +: 2]   = d;
  endtask

  task automatic tick();
    frame_clk = 1'b1;
    cyc(3);
    frame_clk = 1'b0;
    cyc(3);
  endtask

  task automatic expect_cell(input logic [19:0] base, input logic [15:0] data);
    exp_t e;
    for (int w = 0; w < 4; w++) begin
      e.addr = base + 20'(w);
      e.data = data;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s timeout pending_words=%0d busy=%0d required empty/idle",
               nm, sb.size(), busy);
      sb.delete();
    end
  endtask

  initial begin
    int lat;
    int acc0;
    set_p(0, 8'd10, 8'd10, 2'b11);
    set_p(1, 8'd5, 8'd5, 2'b00);
    cyc(3);
    Reset = 1'b0;
    cyc(1);
    chk("reset_fb_we", 32'(fb_we), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_addr", 32'(fb_addr), 32'd0);
    chk("reset_wdata", 32'(fb_wdata), 32'd0);
    chk("reset_collision", 32'(collision), 32'd0);

    // Priming tick: no jobs
    tick();
    cyc(4);
    chk("prime_busy", 32'(busy), 32'd0);

    // P0 moves right (10,10)->(11,10): horizontal, latency and throughput
    set_p(0, 8'd11, 8'd10, 2'b11);
    expect_cell(20'd38524, 16'h0001);
    acc0 = accepts;
    frame_clk = 1'b1;
    lat = 0;
    while (!fb_we && lat < 20) begin
      cyc(1);
      lat++;
    end
`ifdef TRAIL_COLLIDE_EN
    chk("first_word_latency", 32'(lat), 32'd6);
`else
    chk("first_word_latency", 32'(lat), 32'd4);
`endif
    cyc(4);
    chk("one_word_per_cycle", 32'(accepts - acc0), 32'd4);
    frame_clk = 1'b0;
    cyc(3);
    wait_idle("p0_horizontal");

    // P1 turns up->left while moving (5,5)->(4,5): corner, pid 1
    set_p(1, 8'd4, 8'd5, 2'b10);
    expect_cell(20'd32096, 16'h0007);
    tick();
    wait_idle("p1_corner");

    // Both move on one tick with fb_ready toggling: P0 first, then P1
    set_p(0, 8'd11, 8'd11, 2'b11);
    set_p(1, 8'd3, 8'd5, 2'b10);
    expect_cell(20'd39804, 16'h0001);
    expect_cell(20'd32092, 16'h0005);
    acc0 = accepts;
    tog_en = 1'b1;
    tick();
    wait_idle("both_toggle");
    tog_en = 1'b0;
    cyc(1);
    fb_ready = 1'b1;
    chk("both_accepts", 32'(accepts - acc0), 32'd8);

    // Stall on P1 while P0 moves on two ticks: overrun[0], latest P0 cell only
    fb_ready = 1'b0;
    set_p(1, 8'd3, 8'd6, 2'b10);
    expect_cell(20'd33372, 16'h0005);
    acc0 = accepts;
    tick();
    set_p(0, 8'd12, 8'd11, 2'b11);
    tick();
    set_p(0, 8'd13, 8'd11, 2'b11);
    tick();
    chk("overrun_flag", 32'(overrun), 32'd1);
    expect_cell(20'd39812, 16'h0001);
    fb_ready = 1'b1;
    wait_idle("overrun_latest");
    chk("overrun_accepts", 32'(accepts - acc0), 32'd8);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset for two cycles in the middle of a stalled write
    fb_ready = 1'b0;
    set_p(0, 8'd14, 8'd11, 2'b11);
    tick();
    chk("stalled_we", 32'(fb_we), 32'd1);
    Reset = 1'b1;
    cyc(1);
    chk("rst_mid_we", 32'(fb_we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_overrun", 32'(overrun), 32'd0);
    cyc(1);
    Reset = 1'b0;
    fb_ready = 1'b1;
    acc0 = accepts;
    cyc(5);
    set_p(0, 8'd15, 8'd11, 2'b11);
    tick();
    cyc(5);
    chk("rst_prime_busy", 32'(busy), 32'd0);
    chk("rst_no_writes", 32'(accepts - acc0), 32'd0);
    set_p(0, 8'd16, 8'd11, 2'b11);
    expect_cell(20'd39824, 16'h0001);
    tick();
    wait_idle("after_reset");

    // Leaving play abandons a stalled write at once
    fb_ready = 1'b0;
    set_p(0, 8'd17, 8'd11, 2'b11);
    tick();
    chk("exit_stalled_we", 32'(fb_we), 32'd1);
    Game_State = 3'b001;
    #2;
    chk("exit_we_now", 32'(fb_we), 32'd0);
    cyc(2);
    chk("exit_busy", 32'(busy), 32'd0);
    Game_State = 3'b010;
    fb_ready = 1'b1;
    acc0 = accepts;
    cyc(10);
    chk("exit_no_writes", 32'(accepts - acc0), 32'd0);

    // Re-prime, then a move onto an occupied cell
    tick();
    fb_rdata = 16'h0003;
    set_p(0, 8'd18, 8'd11, 2'b11);
    expect_cell(20'd39832, 16'h0001);
    tick();
    wait_idle("collide_write");
    fb_rdata = 16'h0000;
`ifdef TRAIL_COLLIDE_EN
    chk("collision_set", 32'(collision), 32'd1);
    Game_State = 3'b000;
    cyc(2);
    chk("collision_clear", 32'(collision), 32'd0);
    Game_State = 3'b010;
`else
    chk("collision_tied", 32'(collision), 32'd0);
    chk("fb_re_tied", 32'(fb_re), 32'd0);
`endif
    cyc(2);
    chk("end_queue_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trail_writer_mp.md
Name: trail_writer_mp

Overview:
- Parametrised multi-player trail writer; successor to the two-player trail block.
- Once per frame tick, samples every player's cell position and direction, then classifies each move as horizontal, vertical or corner.
- Queues one write job per moving player and serially fills that trail cell into the frame buffer through a ready/valid write port.
- Optional read-before-write check flags collisions per player.

Parameters:
- NUM_PLAYERS, 2, number of players/channels (1..8)
- COORD_W, 8, width of each X/Y cell coordinate
- ADDR_W, 20, frame buffer address width
- DATA_W, 16, frame buffer word width (must be >= PID_W+2)
- CELL_WORDS, 4, consecutive words written per trail cell (>=1)
- ROW_STRIDE, 1280, address increment per cell row
- X_OFF, 20, cell X offset added before address calculation
- Y_OFF, 20, cell Y offset added before address calculation
- PLAY_STATE, 3'b010, Game_State value meaning "in play"

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  frame tick (~60 Hz), level signal; rising edge detected on Clk
- Game_State  in  3  game FSM state
- pos_x  in  NUM_PLAYERS*COORD_W  packed X per player (player p at [p*COORD_W +: COORD_W])
- pos_y  in  NUM_PLAYERS*COORD_W  packed Y per player
- dir  in  NUM_PLAYERS*2  packed direction per player: 00 up, 01 down, 10 left, 11 right
- fb_we  out  1  write valid
- fb_ready  in  1  frame buffer accepts the word when fb_we && fb_ready
- fb_addr  out  ADDR_W  write/read address
- fb_wdata  out  DATA_W  write data
- fb_re  out  1  read strobe (used only with TRAIL_COLLIDE_EN)
- fb_rdata  in  DATA_W  read data, valid 1 Clk after fb_re
- busy  out  1  high when FSM is not in IDLE
- overrun  out  NUM_PLAYERS  sticky: new move detected while that player's job was still pending
- collision  out  NUM_PLAYERS  sticky collision flags (0 without feature)

Behaviour:
- Reset: fb_we=0, fb_re=0, fb_addr=0, fb_wdata=0, busy=0, overrun=0, collision=0, FSM=IDLE, pending=0, primed=0.
- Same clear applies on any Clk where Game_State != PLAY_STATE; an in-flight write is abandoned at once with no further words.
- Tick: frame_clk rising edge, detected with a 1-flop delay. Ticks count only while in play.
- First tick after entering play (primed=0): capture old_x/old_y/old_dir for all players, set primed=1, no jobs.
- Later ticks, per player p:
  - moved = (x != old_x) || (y != old_y).
  - If moved: type = corner (2'd3) when dir != old_dir; else vertical (2'd2) for up/down; else horizontal (2'd1) for left/right.
  - Latch job (x, y, type), set pending[p]. If pending[p] was already set, overwrite the job with the newer one and set overrun[p].
  - Old values update every tick, whether moved or not.
- Cell base address: ((y+Y_OFF)*ROW_STRIDE + (x+X_OFF)*CELL_WORDS), computed at ADDR_W bits; overflow truncates (wraps) mod 2^ADDR_W.
- Word address: base+w for w = 0..CELL_WORDS-1, also wrapping.
- fb_wdata: zero-extended {pid[PID_W-1:0], type[1:0]}, with PID_W = max(1, clog2(NUM_PLAYERS)). The same word is used for every word of the cell.
- FSM states: IDLE, SELECT, CHECK, WAIT_RD, WRITE, NEXT.
  - IDLE -> SELECT when any pending bit is set.
  - SELECT: pick the lowest-index pending player (fixed priority). Go to CHECK with the feature, else to WRITE with w=0.
  - CHECK: fb_re=1, fb_addr=base for one cycle -> WAIT_RD.
  - WAIT_RD: if fb_rdata != 0, set collision[p]. Then go to WRITE.
  - WRITE: fb_we=1, fb_addr/fb_wdata held stable until accepted. On accept: w++; after the last word -> NEXT.
  - NEXT: clear pending[p] (unless a tick re-set it on this same cycle; the tick wins) -> IDLE.
- Latency: with fb_ready held high and no feature, the first word appears 3 Clk after the tick edge reaches the detect flop. One word per cycle follows.
- A tick arriving mid-job only updates job registers of players other than the active one; the active player's job snapshot is frozen in the working registers on SELECT.
- NUM_PLAYERS=1: all logic still valid; pid field is a single 0 bit.

Optional Feature:
- TRAIL_COLLIDE_EN defined: CHECK/WAIT_RD states exist, fb_re is driven, and collision[p] is set sticky when the first word of the target cell reads nonzero. The write still proceeds.
- Undefined: SELECT goes straight to WRITE; fb_re is tied 0 and collision is tied 0.

Test Plan:
- Reset high 2 cycles mid-WRITE -> next cycle fb_we=0, busy=0, overrun=0; no further writes until the second tick in play.
- NUM_PLAYERS=2, P0 moves (10,10)->(11,10) dir 11 unchanged, fb_ready=1 -> 4 writes at 30*1280+31*4=38524..38527, data 16'h0001.
- P1 turns from 00 to 10 while moving (5,5)->(4,5) -> data 16'h0007 (pid1, corner) at 25*1280+24*4=32096..32099.
- Both players move on one tick, fb_ready toggling 1/0 -> all P0 words first, then P1; addr/data stable while ready=0; exactly 8 accepts.
- fb_ready=0 for 2 ticks while P0 moves each tick -> overrun[0]=1; only the latest cell is written once ready rises.
- TRAIL_COLLIDE_EN, fb_rdata=16'h0003 on the CHECK read -> collision[p]=1, the cell is still written, and the flag holds until Game_State leaves PLAY_STATE.
